display_update_ctrl: RTL and testbench
======================================

Name: display_update_ctrl

Overview:
Write-side sequencer for the 8-digit display RAM/scan path. Accepts a binary value with a start/busy/done handshake and converts it to BCD with a sequential double-dabble. It then streams one 6-bit digit word per cycle into the display RAM write port (W/WADD/DIN), with optional decimal point and leading-zero blanking. It sits between the fuzzy-logic result registers and the display interface.

Parameters:
VAL_W, 16, binary input width; legal range 1..26 so the maximum value fits 8 decimal digits.
DIGITS, 8, number of display digits written per update; must match the RAM depth.
DP_ACTIVE_LOW, 1, 1 = a lit decimal point is written as DIN[0]=0.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  update request; sampled only in IDLE
value  in  VAL_W  unsigned binary value; latched when start is accepted
dp_en  in  1  enable decimal point; latched with value
dp_pos  in  3  digit index carrying the DP; latched with value
busy  out  1  high from the accept cycle until the done cycle inclusive
done  out  1  one-cycle pulse after the last RAM write
W  out  1  RAM write enable
WADD  out  3  RAM write address = digit index; 0 = least significant digit
DIN  out  6  RAM word: [5]=digit enable, [4:1]=BCD, [0]=DP pin level

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, W=0, WADD=0, DIN=0; BCD/shift registers cleared.
- IDLE:
  - start=1 → latch value, dp_en, dp_pos; busy=1 from the next edge; go to CONV.
  - start=0 → stay in IDLE, all outputs at idle values.
- CONV:
  - Exactly VAL_W cycles of double-dabble over a 4*DIGITS-bit BCD register.
  - Each cycle: add 3 to every nibble ≥5, then shift left one bit, bringing in the MSB of the remaining value.
  - W=0 throughout. Then go to WRITE.
- WRITE:
  - DIGITS consecutive cycles with W=1; WADD counts 0..DIGITS-1.
  - DIN[4:1] = nibble WADD.
  - DIN[0] = lit if (dp_en && WADD==dp_pos), else unlit; lit level = ~DP_ACTIVE_LOW.
  - DIN[5] set by the blanking rule (Optional Feature).
  - After WADD=DIGITS-1, go to DONE.
- DONE: one cycle; done=1, W=0, busy=1. Then IDLE with busy=0.
- Latency: first W=1 occurs VAL_W+1 cycles after the accept edge; done occurs VAL_W+DIGITS+1 cycles after it.
- start while busy: ignored; no queuing.
- start high on the cycle after done: accepted as a new update; back-to-back updates are allowed.
- Reset mid-CONV or mid-WRITE: sequence aborts, W drops immediately, no further writes. RAM keeps the words already written (partial update is acceptable).
- dp_pos ≥ DIGITS: no DP lit.
- value changes while busy: no effect; the latched copy is used.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - DIN[5]=0 (blank) for every digit above the most significant nonzero nibble.
  - Digit 0 is always enabled, so value 0 shows "0".
  - A digit carrying a lit DP is never blanked.
- Undefined: DIN[5]=1 on every digit; leading zeros are displayed.

Decomposition:
- Package display_pkg:
  - state enum {IDLE, CONV, WRITE, DONE}
  - DIN field positions: DIN_EN=5, DIN_BCD_HI=4, DIN_BCD_LO=1, DIN_DP=0
  - DISP_DIGITS=8
  - DIN_BLANK constant
- Sub-module bin2bcd_seq (load/shift/done, parameterised VAL_W/DIGITS) holds the double-dabble. The top holds the FSM, write counter and blank/DP logic.

Test Plan (defaults, macro defined, DP_ACTIVE_LOW=1):
- Reset: hold rst_n=0 → busy=0, done=0, W=0, WADD=0, DIN=0. Release with start=0 → no writes for 50 cycles.
- value=1234, dp_en=0, start pulse:
  - First W=1 at accept+17.
  - WADD0..7 DIN = 0x29, 0x27, 0x25, 0x23, 0x01, 0x01, 0x01, 0x01.
  - done at accept+25, single cycle.
- value=0 → DIN = 0x21 at WADD0, 0x01 at WADD1..7.
- value=65535, dp_en=1, dp_pos=2 → DIN = 0x2B, 0x27, 0x2A, 0x2B, 0x2D, 0x01, 0x01, 0x01 (WADD2 DP lit).
- Macro undefined, value=7 → DIN = 0x2F, then 0x21 ×7.
- Handshake and reset:
  - start held high for 40 cycles → exactly two updates; the second is accepted the cycle after the first done.
  - rst_n pulsed low while WADD=3 → W=0 within the same cycle, busy=0.
  - A subsequent start completes a normal 8-write update.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the display write-side sequencer.
//   state_t      : sequencer states
//   DIN_*        : bit positions of the 6-bit display RAM word
//   DISP_DIGITS  : number of digits on the display (RAM depth)
//   DIN_BLANK    : digit-enable level that blanks a digit
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DIN_EN      = 5;
    localparam int DIN_BCD_HI  = 4;
    localparam int DIN_BCD_LO  = 1;
    localparam int DIN_DP      = 0;

    localparam int DISP_DIGITS = 8;

    localparam logic DIN_BLANK = 1'b0;

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture value, clear the BCD register, arm VAL_W steps
//   shift      : perform one add-3/shift step (ignored once all steps are done)
//   value      : unsigned binary input
//   bcd        : 4*DIGITS-bit BCD result, nibble 0 = least significant digit
//   done       : high once all VAL_W steps have been performed
module bin2bcd_seq #(
    parameter int VAL_W  = 16,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [VAL_W-1:0]      value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0]    bin;
    logic [CNT_W-1:0]    steps_left;
    logic [4*DIGITS-1:0] adjusted;

    always_comb begin
        adjusted = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin        <= '0;
            bcd        <= '0;
            steps_left <= '0;
        end else if (load) begin
            bin        <= value;
            bcd        <= '0;
            steps_left <= CNT_W'(VAL_W);
        end else if (shift && steps_left != '0) begin
            bcd        <= {adjusted[4*DIGITS-2:0], bin[VAL_W-1]};
            bin        <= bin << 1;
            steps_left <= steps_left - 1'b1;
        end
    end

    assign done = (steps_left == '0);

endmodule

// File: rtl/display_update_ctrl.sv
// display_update_ctrl: converts a binary value to BCD and streams one 6-bit
// word per digit into the display RAM write port.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : update request, sampled only while idle
//   value          : unsigned binary value, latched on accept
//   dp_en, dp_pos  : decimal point enable and digit index, latched on accept
//   busy           : high from the accept cycle through the done cycle
//   done           : one-cycle pulse after the last RAM write
//   W, WADD, DIN   : RAM write enable, digit address, word {en, bcd[3:0], dp}
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module display_update_ctrl
    import display_pkg::*;
#(
    parameter int VAL_W         = 16,
    parameter int DIGITS        = DISP_DIGITS,
    parameter int DP_ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    input  logic             dp_en,
    input  logic [2:0]       dp_pos,
    output logic             busy,
    output logic             done,
    output logic             W,
    output logic [2:0]       WADD,
    output logic [5:0]       DIN
);

    localparam logic       DP_LIT   = (DP_ACTIVE_LOW == 0) ? 1'b1 : 1'b0;
    localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

    state_t              state, state_next;
    logic                load, shift, conv_done;
    logic [4*DIGITS-1:0] bcd;
    logic [2:0]          wr_cnt;
    logic                dp_en_q;
    logic [2:0]          dp_pos_q;
    logic [3:0]          nib [DIGITS];
    logic                dp_here;
    logic                digit_en;

    bin2bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .value (value),
        .bcd   (bcd),
        .done  (conv_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_cnt   <= '0;
            dp_en_q  <= 1'b0;
            dp_pos_q <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                dp_en_q  <= dp_en;
                dp_pos_q <= dp_pos;
            end
            if (state == WRITE && wr_cnt != LAST_IDX)
                wr_cnt <= wr_cnt + 1'b1;
            else
                wr_cnt <= '0;
        end
    end

    // The converter's done flag is registered, so CONV spans VAL_W shift
    // cycles plus the cycle in which done is observed.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (conv_done)
                    state_next = WRITE;
                else
                    shift = 1'b1;
            end
            WRITE: begin
                if (wr_cnt == LAST_IDX)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++)
            nib[i] = bcd[4*i +: 4];
    end

    assign dp_here = dp_en_q && (dp_pos_q == wr_cnt);

`ifdef LEADING_ZERO_BLANK_EN
    // Digits above the most significant nonzero nibble are blanked; digit 0
    // and any digit carrying the DP always stay enabled.
    logic [2:0] msnz;
    always_comb begin
        msnz = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (nib[i] != '0)
                msnz = 3'(i);
        end
        digit_en = (wr_cnt <= msnz) || dp_here;
    end
`else
    assign digit_en = ~DIN_BLANK;
`endif

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
        W    = 1'b0;
        WADD = '0;
        DIN  = '0;
        if (state == WRITE) begin
            W                         = 1'b1;
            WADD                      = wr_cnt;
            DIN[DIN_EN]               = digit_en;
            DIN[DIN_BCD_HI:DIN_BCD_LO] = nib[wr_cnt];
            DIN[DIN_DP]               = dp_here ? DP_LIT : ~DP_LIT;
        end
    end

endmodule

// File: tb/tb_display_update_ctrl.sv
module tb_display_update_ctrl;

    localparam int VAL_W  = 16;
    localparam int DIGITS = 8;
    localparam int FIRST_W = VAL_W + 1;
    localparam int DONE_K  = VAL_W + DIGITS + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [VAL_W-1:0] value = '0;
    logic             dp_en = 1'b0;
    logic [2:0]       dp_pos = '0;
    logic             busy, done, W;
    logic [2:0]       WADD;
    logic [5:0]       DIN;

    int checks = 0;
    int failures = 0;

    display_update_ctrl #(
        .VAL_W         (VAL_W),
        .DIGITS        (DIGITS),
        .DP_ACTIVE_LOW (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .value  (value),
        .dp_en  (dp_en),
        .dp_pos (dp_pos),
        .busy   (busy),
        .done   (done),
        .W      (W),
        .WADD   (WADD),
        .DIN    (DIN)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digit idx of val, written as the display word.
    function automatic logic [5:0] model_din(input int unsigned val, input bit dpe,
                                             input int unsigned dpp, input int unsigned idx);
        longint unsigned p;
        int unsigned d;
        bit lit, en;
        p = 1;
        for (int j = 0; j < int'(idx); j++) p = p * 10;
        d = int'((longint'(val) / p) % 10);
        lit = dpe && (dpp == idx);
`ifdef LEADING_ZERO_BLANK_EN
        en = (idx == 0) || (longint'(val) >= p) || lit;
`else
        en = 1'b1;
`endif
        return {en, d[3:0], ~lit};
    endfunction

    // Expected {busy,done,W,WADD,DIN} k cycles after the accept edge.
    function automatic logic [11:0] model_out(input int unsigned val, input bit dpe,
                                              input int unsigned dpp, input int k);
        logic b, dn, w;
        logic [2:0] a;
        logic [5:0] d;
        b  = (k <= DONE_K);
        dn = (k == DONE_K);
        w  = (k >= FIRST_W) && (k < FIRST_W + DIGITS);
        a  = w ? 3'(k - FIRST_W) : 3'd0;
        d  = w ? model_din(val, dpe, dpp, int'(a)) : 6'd0;
        return {b, dn, w, a, d};
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic run_update(input int unsigned val, input bit dpe, input int unsigned dpp);
        value  = VAL_W'(val);
        dp_en  = dpe;
        dp_pos = 3'(dpp);
        start  = 1'b1;
        for (int k = 0; k <= DONE_K + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start  = 1'b0;
                value  = VAL_W'($urandom);
                dp_en  = 1'($urandom);
                dp_pos = 3'($urandom);
            end
            check($sformatf("upd v=%0d k=%0d", val, k),
                  {20'd0, busy, done, W, WADD, DIN}, {20'd0, model_out(val, dpe, dpp, k)});
        end
    endtask

    initial begin
        int done_cnt, w_cnt, rise_k;
        bit prev_busy, found;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {20'd0, busy, done, W, WADD, DIN}, 32'd0);
        rst_n = 1'b1;
        w_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (W || busy) w_cnt++;
        end
        check("idle_no_writes", w_cnt, 0);

        // Directed updates
        run_update(1234, 1'b0, 0);
        run_update(0, 1'b0, 0);
        run_update(65535, 1'b1, 2);
        run_update(7, 1'b0, 0);
        run_update(10, 1'b1, 6);

        // Randomised updates
        for (int n = 0; n < 12; n++)
            run_update($urandom_range(0, 65535), 1'($urandom), $urandom_range(0, 7));

        // start held high for 40 cycles: two back-to-back updates
        value = VAL_W'(42); dp_en = 1'b0; start = 1'b1;
        done_cnt = 0; w_cnt = 0; rise_k = -1; prev_busy = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 39) start = 1'b0;
            if (done) done_cnt++;
            if (W) w_cnt++;
            if (k > 0 && busy && !prev_busy && rise_k < 0) rise_k = k;
            prev_busy = busy;
        end
        check("held_start_done_pulses", done_cnt, 2);
        check("held_start_writes", w_cnt, 2 * DIGITS);
        check("held_start_second_accept", rise_k, DONE_K + 2);

        // Reset in the middle of WRITE
        value = VAL_W'(9876); start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (W && WADD == 3'd3) found = 1'b1;
        end
        check("reach_wadd3", {31'd0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("midreset_w_busy", {30'd0, W, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        w_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (W || busy) w_cnt++;
        end
        check("after_reset_quiet", w_cnt, 0);

        run_update(4321, 1'b1, 0);
        run_update(99, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
